// File: rtl/lab3_multicycle_cla_adder_if.sv
// ---------------------------------------------------------------------------
// lab3_multicycle_cla_adder_if
// Bundles the operand/request and result/status signals of the multi-cycle
// CLA adder so a controller and the adder connect with a single port.
//
// Optional feature macro: SUB_EN (adds the 'sub' request bit).
//
// Signals:
//   start  controller -> adder  request, honoured only while the adder idles
//   A, B   controller -> adder  WIDTH-bit operands, captured on acceptance
//   Cin    controller -> adder  carry-in, captured on acceptance
//   sub    controller -> adder  (SUB_EN only) 1 = compute A-B
//   busy   adder -> controller  slices are being processed
//   done   adder -> controller  one-cycle pulse, result valid
//   Sum    adder -> controller  registered WIDTH-bit result
//   Cout   adder -> controller  carry out of the MSB
//   Ovf    adder -> controller  signed overflow
//
// Modports: master = controller side, slave = adder side.
// ---------------------------------------------------------------------------
interface lab3_multicycle_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
`ifdef SUB_EN
        output sub,
`endif
        output start, A, B, Cin,
        input  busy, done, Sum, Cout, Ovf
    );

    modport slave (
`ifdef SUB_EN
        input  sub,
`endif
        input  start, A, B, Cin,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/lab3_multicycle_cla_adder.sv
// ---------------------------------------------------------------------------
// lab3_multicycle_cla_adder
// Adds two WIDTH-bit operands one 4-bit carry-lookahead slice per clock,
// least-significant nibble first. A registered carry links consecutive
// slices, so the per-cycle combinational path is a single 4-bit lookahead
// slice. A start/busy/done handshake frames each operation:
//   IDLE --start--> RUN (N = WIDTH/4 cycles) --> DONE (1 cycle) --> IDLE
//
// Optional feature macro: SUB_EN. When defined, a 'sub' request bit selects
// A-B (B captured inverted, carry-in forced to 1, Cin ignored).
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  slave side of lab3_multicycle_cla_adder_if (start, A, B, Cin,
//        [sub] in; busy, done, Sum, Cout, Ovf out)
// ---------------------------------------------------------------------------
module lab3_multicycle_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    lab3_multicycle_cla_adder_if.slave    bus
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("lab3_multicycle_cla_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Operand registers: only meaningful after a load, so they carry no reset.
    logic [WIDTH-1:0] a_q, b_q;
    logic             load;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;

    logic [3:0]       a_nib, b_nib, s_nib;
    logic             c3, c4;

    // One 4-bit lookahead slice. Returns {c4, c3, sum[3:0]}.
    // Carries are flattened sum-of-products so no carry ripples within the
    // slice; c3 is kept for the signed-overflow term of the last slice.
    function automatic logic [5:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       c0);
        logic [3:0] p, g, c;
        logic       c4_f;
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c0);
        c4_f = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4_f, c[3], p ^ c};
    endfunction

    // Operand conditioning at the accepting edge.
`ifdef SUB_EN
    // Two's-complement subtraction: A + ~B + 1.
    assign b_in   = bus.sub ? ~bus.B : bus.B;
    assign cin_in = bus.sub ? 1'b1   : bus.Cin;
`else
    assign b_in   = bus.B;
    assign cin_in = bus.Cin;
`endif

    // Current slice selected by the counter, chained through carry_q.
    assign a_nib = a_q[4*k_q +: 4];
    assign b_nib = b_q[4*k_q +: 4];
    assign {c4, c3, s_nib} = cla4(a_nib, b_nib, carry_q);

    // State and control/result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= bus.A;
            b_q <= b_in;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    k_d     = '0;
                    carry_d = cin_in;
                    work_d  = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                work_d[4*k_q +: 4] = s_nib;
                carry_d            = c4;
                if (k_q == LAST_K) begin
                    // Publish the whole word at once so Sum never shows a
                    // partially built result.
                    sum_d   = work_d;
                    cout_d  = c4;
                    ovf_d   = c3 ^ c4;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_lab3_multicycle_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_lab3_multicycle_cla_adder
// Directed vectors with hand-computed results. The stimulus process pushes
// the expected result into a queue when an operation is accepted; the
// monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_lab3_multicycle_cla_adder;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic clk;
    logic rst;

    lab3_multicycle_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    lab3_multicycle_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } exp_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] held_sum = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares results as they appear, independent of stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy && bus.done)
                check("busy_done_exclusive", 32'd1, 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("Sum",  32'(bus.Sum),  32'(e.s));
                    check("Cout", 32'(bus.Cout), 32'(e.c));
                    check("Ovf",  32'(bus.Ovf),  32'(e.v));
                end
            end
        end
    end

    // Issue one operation, check latency, busy length and that Sum holds the
    // previous result while running.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sb,
                         input logic [WIDTH-1:0] es, input logic ec,
                         input logic ev);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
`ifdef SUB_EN
        bus.sub   = sb;
`endif
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        exp_q.push_back('{s: es, c: ec, v: ev});
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.busy) begin
                busy_cnt++;
                check("Sum_held_in_run", 32'(bus.Sum), 32'(held_sum));
            end
        end while (!bus.done && cyc < 50);
        check("done_latency", cyc, N + 1);
        check("busy_cycles", busy_cnt, N);
        held_sum = es;
        @(posedge clk);
        if (sb) begin end
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
`ifdef SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_Sum",  32'(bus.Sum),  32'd0);
        check("rst_Cout", 32'(bus.Cout), 32'd0);
        check("rst_Ovf",  32'(bus.Ovf),  32'd0);
        rst = 1'b0;

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        // start held high through RUN and DONE with new operands: ignored.
        @(negedge clk);
        bus.A     = 16'h0001;
        bus.B     = 16'h0001;
        bus.Cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{s: 16'h0002, c: 1'b0, v: 1'b0});
        bus.A = 16'hFFFF;
        bus.B = 16'hFFFF;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 50);
        check("ign_done_latency", cyc, N + 1);
        @(posedge clk);          // DONE -> IDLE edge, start still high
        #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ign_no_restart_busy", 32'(bus.busy), 32'd0);
        end
        held_sum = 16'h0002;

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        bus.A     = 16'hAAAA;
        bus.B     = 16'h5555;
        bus.Cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_Sum",  32'(bus.Sum),  32'd0);
        check("abort_Cout", 32'(bus.Cout), 32'd0);
        check("abort_Ovf",  32'(bus.Ovf),  32'd0);
        @(negedge clk);
        rst      = 1'b0;
        held_sum = '0;
        repeat (N + 3) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end

        issue(16'h0F0F, 16'h0101, 1'b1, 1'b0, 16'h1011, 1'b0, 1'b0);

`ifdef SUB_EN
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
